mnist_sample_loader: RTL

//  Training-sample sequencer feeding the ten per-class pseudo-linear learners.

---
 rtl/mnist_sample_loader.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mnist_sample_loader.sv
// Training-sample sequencer: fetches packed 794-bit MNIST samples (784 pixels
// plus a 10-bit one-hot label) from a sync-read word memory, holds each one on
// image_data for HOLD_CYCLES clocks, and loops over samples and epochs.
// Optional feature macro: LOADER_LABEL_CHECK_EN adds a one-cycle CHECK state
// that skips samples whose label is not one-hot and counts them.
module mnist_sample_loader #(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 20,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       num_samples,
  input  logic [7:0]        num_epochs,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [793:0]      image_data,
  output logic              sample_valid,
  output logic [15:0]       sample_idx,
  output logic [7:0]        epoch_idx,
  output logic              busy,
  output logic              done,
  output logic [15:0]       label_err_cnt
);

  localparam int IMG_W  = 794;
  localparam int BEATS  = (IMG_W + WORD_W - 1) / WORD_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BEATS_A   = ADDR_W'(BEATS);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_CHECK, S_PRESENT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       idx_q, idx_d;
  logic [7:0]        epoch_q, epoch_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       ns_q, ns_d;
  logic [7:0]        ne_q, ne_d;
  logic              rd_pend_q, rd_pend_d;
  logic [BEAT_W-1:0] rd_beat_q, rd_beat_d;
  logic              zdone_q, zdone_d;
  logic [IMG_W-1:0]  shadow_q, shadow_d;
  logic              advance;
`ifdef LOADER_LABEL_CHECK_EN
  logic [15:0]       err_q, err_d;
`endif

  // Merge the word returned for the previous strobe into the shadow image;
  // bits past the 794-bit image are simply never written.
  always_comb begin
    shadow_d = shadow_q;
    if (rd_pend_q && !abort) begin
      for (int k = 0; k < IMG_W; k++) begin
        if (k / WORD_W == int'(rd_beat_q)) shadow_d[k] = mem_rdata[k % WORD_W];
      end
    end
  end

  // Next-state logic: fetch sequencing, hold timing, index/epoch advance.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave one unassigned and infer a latch.
    state_d   = state_q;
    beat_d    = beat_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    epoch_d   = epoch_q;
    base_d    = base_q;
    ns_d      = ns_q;
    ne_d      = ne_q;
    rd_pend_d = 1'b0;
    rd_beat_d = rd_beat_q;
    zdone_d   = 1'b0;
    advance   = 1'b0;
`ifdef LOADER_LABEL_CHECK_EN
    err_d     = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef LOADER_LABEL_CHECK_EN
          err_d = '0;
`endif
          if (num_samples != 16'd0 && num_epochs != 8'd0) begin
            ns_d    = num_samples;
            ne_d    = num_epochs;
            idx_d   = '0;
            epoch_d = '0;
            base_d  = '0;
            beat_d  = '0;
            state_d = S_FETCH;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        rd_pend_d = 1'b1;
        rd_beat_d = beat_q;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = S_DRAIN;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_DRAIN: begin
        hold_d = '0;
`ifdef LOADER_LABEL_CHECK_EN
        state_d = S_CHECK;
`else
        state_d = S_PRESENT;
`endif
      end
`ifdef LOADER_LABEL_CHECK_EN
      S_CHECK: begin
        if ($countones(shadow_q[9:0]) != 1) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          advance = 1'b1;
        end else begin
          state_d = S_PRESENT;
        end
      end
`endif
      S_PRESENT: begin
        if (hold_q == LAST_HOLD) advance = 1'b1;
        else                     hold_d  = hold_q + HOLD_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (idx_q == ns_q - 16'd1) begin
        idx_d   = '0;
        base_d  = '0;
        epoch_d = epoch_q + 8'd1;
        state_d = (epoch_q == ne_q - 8'd1) ? S_DONE : S_FETCH;
      end else begin
        idx_d   = idx_q + 16'd1;
        base_d  = base_q + BEATS_A;
        state_d = S_FETCH;
      end
    end

    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      state_d   = S_IDLE;
      rd_pend_d = 1'b0;
      zdone_d   = 1'b0;
      idx_d     = '0;
      epoch_d   = '0;
      base_d    = '0;
      beat_d    = '0;
      hold_d    = '0;
`ifdef LOADER_LABEL_CHECK_EN
      err_d     = err_q;
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      hold_q    <= '0;
      idx_q     <= '0;
      epoch_q   <= '0;
      base_q    <= '0;
      ns_q      <= '0;
      ne_q      <= '0;
      rd_pend_q <= 1'b0;
      rd_beat_q <= '0;
      zdone_q   <= 1'b0;
      // NOTE: the shadow is a flop array, not a RAM, so clearing it on reset is legal and keeps image_data defined.
      shadow_q  <= '0;
`ifdef LOADER_LABEL_CHECK_EN
      err_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q   <= state_d;
      beat_q    <= beat_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      epoch_q   <= epoch_d;
      base_q    <= base_d;
      ns_q      <= ns_d;
      ne_q      <= ne_d;
      rd_pend_q <= rd_pend_d;
      rd_beat_q <= rd_beat_d;
      zdone_q   <= zdone_d;
      shadow_q  <= shadow_d;
`ifdef LOADER_LABEL_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign mem_rd_en    = (state_q == S_FETCH);
  assign mem_addr     = mem_rd_en ? (base_q + ADDR_W'(beat_q)) : '0;
  assign sample_valid = (state_q == S_PRESENT);
  assign image_data   = sample_valid ? shadow_q : '0;
  assign sample_idx   = idx_q;
  assign epoch_idx    = epoch_q;
  assign done         = (state_q == S_DONE) || zdone_q;
`ifdef LOADER_LABEL_CHECK_EN
  assign label_err_cnt = err_q;
`else
  assign label_err_cnt = 16'd0;
`endif

endmodule
